// File: rtl/ahb_lite_ram_slave.sv
// AHB-Lite responder in front of a word-organised RAM, with optional wait states,
// two-cycle ERROR responses and read-after-write forwarding.
module ahb_lite_ram_slave #(
   parameter int ADDR_WIDTH  = 12,
   parameter int MEM_WORDS   = 4096,
   parameter int WAIT_STATES = 0
) (
   input  logic        HCLK,
   input  logic        SI_Reset,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic [2:0]  HSIZE,
   input  logic        HWRITE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_LAST = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } state_t;

   localparam logic [3:0]          LP_WAIT  = 4'(WAIT_STATES);
   localparam logic [ADDR_WIDTH:0] LP_LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS);

   function automatic logic [3:0] f_lanes(input logic [1:0] size, input logic [1:0] lo);
      logic [3:0] be;
      case (size)
         2'd0:    be = 4'b0001 << lo;
         2'd1:    be = lo[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] f_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
      logic [31:0] res;
      res = old_w;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
         else       res[8*i +: 8] = old_w[8*i +: 8];
      end
      return res;
   endfunction

   logic [31:0]           r_mem [0:MEM_WORDS-1];
   state_t                r_state;
   state_t                w_next;
   logic [3:0]            r_cnt;
   logic [3:0]            w_cnt_next;
   logic [ADDR_WIDTH-1:0] r_word;
   logic [1:0]            r_lo;
   logic [1:0]            r_size;
   logic                  r_write;
   logic [31:0]           r_hrdata;
   logic                  r_hreadyout;
   logic                  r_hresp;

   logic                  w_accept;
   logic                  w_take;
   logic                  w_err;
   logic                  w_commit;
   logic [3:0]            w_be;
   logic                  w_ld_en;
   logic [ADDR_WIDTH-1:0] w_ld_word;
   logic [31:0]           w_rd_val;
   logic                  w_unused_bits;

   assign w_unused_bits = ^{HTRANS[0], HADDR[31:ADDR_WIDTH+2]};

   assign w_accept = HSEL & HREADY & HTRANS[1];
   assign w_take   = w_accept & ((r_state == ST_IDLE) | (r_state == ST_LAST) | (r_state == ST_ERR2));
   assign w_err    = (HSIZE > 3'd2)
                   | ((HSIZE == 3'd1) & HADDR[0])
                   | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00))
                   | ({1'b0, HADDR[ADDR_WIDTH+1:2]} >= LP_LIMIT);

   // A reset arriving in the final cycle must drop the pending write.
   assign w_commit = (r_state == ST_LAST) & r_write & ~SI_Reset;
   assign w_be     = f_lanes(r_size, r_lo);

   // Next-state and wait-counter logic.
   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      case (r_state)
         ST_IDLE, ST_LAST, ST_ERR2: begin
            if (w_take) begin
               if (w_err) begin
                  w_next = ST_ERR1;
               end else if (LP_WAIT != 4'd0) begin
                  w_next     = ST_WAIT;
                  w_cnt_next = LP_WAIT;
               end else begin
                  w_next = ST_LAST;
               end
            end else begin
               w_next = ST_IDLE;
            end
         end
         ST_WAIT: begin
            w_cnt_next = r_cnt - 4'd1;
            if (r_cnt == 4'd1) w_next = ST_LAST;
            else               w_next = ST_WAIT;
         end
         ST_ERR1: w_next = ST_ERR2;
         default: w_next = ST_IDLE;
      endcase
   end

   // Selects which word, if any, is loaded into HRDATA on the edge entering LAST.
   always_comb begin
      w_ld_en   = 1'b0;
      w_ld_word = r_word;
      if (w_take && !w_err && (LP_WAIT == 4'd0)) begin
         w_ld_en   = ~HWRITE;
         w_ld_word = HADDR[ADDR_WIDTH+1:2];
      end else if ((r_state == ST_WAIT) && (r_cnt == 4'd1)) begin
         w_ld_en   = ~r_write;
         w_ld_word = r_word;
      end else begin
         w_ld_en   = 1'b0;
         w_ld_word = r_word;
      end
   end

   // Forward bytes of a write committing on the same edge to the same word.
   always_comb begin
      w_rd_val = r_mem[w_ld_word];
      if (w_commit && (r_word == w_ld_word)) w_rd_val = f_merge(r_mem[w_ld_word], HWDATA, w_be);
      else                                   w_rd_val = r_mem[w_ld_word];
   end

   // State, counter, captured address phase and registered bus outputs.
   always_ff @(posedge HCLK or posedge SI_Reset) begin
      if (SI_Reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 4'd0;
         r_word      <= '0;
         r_lo        <= 2'd0;
         r_size      <= 2'd0;
         r_write     <= 1'b0;
         r_hrdata    <= 32'd0;
         r_hreadyout <= 1'b1;
         r_hresp     <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_cnt       <= w_cnt_next;
         r_hreadyout <= (w_next != ST_WAIT) && (w_next != ST_ERR1);
         r_hresp     <= (w_next == ST_ERR1) || (w_next == ST_ERR2);
         if (w_take) begin
            r_word  <= HADDR[ADDR_WIDTH+1:2];
            r_lo    <= HADDR[1:0];
            r_size  <= HSIZE[1:0];
            r_write <= HWRITE;
         end
         if (w_ld_en) r_hrdata <= w_rd_val;
      end
   end

   // RAM array; contents survive reset.
   always_ff @(posedge HCLK) begin
      if (w_commit) r_mem[r_word] <= f_merge(r_mem[r_word], HWDATA, w_be);
   end

   assign HRDATA    = r_hrdata;
   assign HREADYOUT = r_hreadyout;
   assign HRESP     = r_hresp;

endmodule

// File: tb/tb_ahb_lite_ram_slave.sv
// Directed bench: three slaves (0, 2, 3 wait states) on a shared bus, a reference
// RAM model and a scoreboard of expected data-phase results.
module tb_ahb_lite_ram_slave;

   localparam logic [1:0] T_IDLE = 2'd0;
   localparam logic [1:0] T_BUSY = 2'd1;
   localparam logic [1:0] T_NSEQ = 2'd2;

   typedef struct {
      logic        err;
      logic        rd;
      logic [31:0] data;
      int          waits;
   } exp_t;

   logic        HCLK = 1'b0;
   logic        SI_Reset;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic        HWRITE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        ext_stall;
   int          act;

   logic [31:0] rdata_a [3];
   logic        ready_a [3];
   logic        resp_a  [3];

   exp_t        sb[$];
   logic [31:0] mdl [3][256];
   logic [31:0] pend_wdata;
   int          checks = 0;
   int          errors = 0;

   always #5 HCLK = ~HCLK;

   assign HREADY = ext_stall ? 1'b0 : ready_a[act];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      ahb_lite_ram_slave #(
         .ADDR_WIDTH (8),
         .MEM_WORDS  (200),
         .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 2 : 3))
      ) u_dut (
         .HCLK     (HCLK),
         .SI_Reset (SI_Reset),
         .HSEL     (HSEL & (act == g)),
         .HADDR    (HADDR),
         .HTRANS   (HTRANS),
         .HSIZE    (HSIZE),
         .HWRITE   (HWRITE),
         .HWDATA   (HWDATA),
         .HREADY   (HREADY),
         .HRDATA   (rdata_a[g]),
         .HREADYOUT(ready_a[g]),
         .HRESP    (resp_a[g])
      );
   end

   function automatic int ws_of(input int k);
      return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
   endfunction

   function automatic logic exp_err(input logic [31:0] a, input logic [2:0] sz);
      return (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00) || (a[9:2] >= 8'd200);
   endfunction

   function automatic logic [31:0] lane_mask(input logic [31:0] a, input logic [2:0] sz);
      if (sz == 3'd0)      return 32'h0000_00FF << (8 * a[1:0]);
      else if (sz == 3'd1) return 32'h0000_FFFF << (16 * a[1]);
      else                 return 32'hFFFF_FFFF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One pipelined master cycle: present an address phase, finish the previous data phase.
   task automatic bus(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                      input logic [2:0] sz, input logic wr, input logic [31:0] wd);
      int          n;
      exp_t        e;
      logic [31:0] m;
      HSEL = sel; HTRANS = tr; HADDR = a; HSIZE = sz; HWRITE = wr; HWDATA = pend_wdata;
      n = 0;
      while (HREADY !== 1'b1 && n < 40) begin
         if (sb.size() > 0) chk("resp_during_stall", {31'd0, resp_a[act]}, {31'd0, sb[0].err});
         @(posedge HCLK); @(negedge HCLK);
         n++;
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("wait_cycles", n, e.waits);
         chk("resp", {31'd0, resp_a[act]}, {31'd0, e.err});
         if (e.rd && !e.err) chk("rdata", rdata_a[act], e.data);
      end else begin
         chk("idle_ready", n, 0);
      end
      if (sel && tr[1]) begin
         e.err   = exp_err(a, sz);
         e.rd    = ~wr;
         e.waits = e.err ? 1 : ws_of(act);
         e.data  = 32'd0;
         if (!e.err) begin
            m = lane_mask(a, sz);
            if (wr) mdl[act][a[9:2]] = (mdl[act][a[9:2]] & ~m) | (wd & m);
            e.data = mdl[act][a[9:2]];
         end
         sb.push_back(e);
      end
      pend_wdata = wd;
      @(posedge HCLK); @(negedge HCLK);
   endtask

   initial begin
      SI_Reset = 1'b1; HSEL = 1'b0; HADDR = 32'd0; HTRANS = T_IDLE; HSIZE = 3'd2;
      HWRITE = 1'b0; HWDATA = 32'd0; ext_stall = 1'b0; act = 0; pend_wdata = 32'd0;
      repeat (3) @(negedge HCLK);
      SI_Reset = 1'b0;
      @(negedge HCLK);
      for (int k = 0; k < 3; k++) begin
         chk("reset_ready", {31'd0, ready_a[k]}, 32'd1);
         chk("reset_resp", {31'd0, resp_a[k]}, 32'd0);
         chk("reset_rdata", rdata_a[k], 32'd0);
      end

      // Reset during the wait phase of a write must leave the old word in place.
      act = 1;
      bus(1'b1, T_NSEQ, 32'h14, 3'd2, 1'b1, 32'h1111_1111);
      bus(1'b0, T_IDLE, 32'h0, 3'd2, 1'b0, 32'h0);
      HSEL = 1'b1; HTRANS = T_NSEQ; HADDR = 32'h14; HSIZE = 3'd2; HWRITE = 1'b1;
      @(posedge HCLK); @(negedge HCLK);
      HSEL = 1'b0; HTRANS = T_IDLE; HWDATA = 32'h2222_2222;
      chk("wait_before_reset", {31'd0, ready_a[1]}, 32'd0);
      SI_Reset = 1'b1;
      #1;
      chk("async_reset_ready", {31'd0, ready_a[1]}, 32'd1);
      @(posedge HCLK); @(negedge HCLK);
      SI_Reset = 1'b0;
      @(negedge HCLK);
      bus(1'b1, T_NSEQ, 32'h14, 3'd2, 1'b0, 32'h0);
      bus(1'b0, T_IDLE, 32'h0, 3'd2, 1'b0, 32'h0);

      // Zero wait states: write then immediate read of the same word, then sub-word writes.
      act = 0;
      bus(1'b1, T_NSEQ, 32'h10, 3'd2, 1'b1, 32'hDEAD_BEEF);
      bus(1'b1, T_NSEQ, 32'h10, 3'd2, 1'b0, 32'h0);
      bus(1'b1, T_NSEQ, 32'h20, 3'd2, 1'b1, 32'h0000_0000);
      bus(1'b1, T_NSEQ, 32'h21, 3'd0, 1'b1, 32'h11AA_2233);
      bus(1'b1, T_NSEQ, 32'h22, 3'd1, 1'b1, 32'h5566_7788);
      bus(1'b1, T_NSEQ, 32'h20, 3'd2, 1'b0, 32'h0);
      bus(1'b1, T_NSEQ, 32'h20, 3'd0, 1'b0, 32'h0);
      bus(1'b0, T_IDLE, 32'h0, 3'd2, 1'b0, 32'h0);

      // Three wait states, back-to-back transfers.
      act = 2;
      bus(1'b1, T_NSEQ, 32'h1C, 3'd2, 1'b1, 32'hCAFE_F00D);
      bus(1'b1, T_NSEQ, 32'h20, 3'd2, 1'b1, 32'h0102_0304);
      bus(1'b1, T_NSEQ, 32'h1C, 3'd2, 1'b0, 32'h0);
      bus(1'b1, T_NSEQ, 32'h20, 3'd2, 1'b0, 32'h0);
      bus(1'b0, T_IDLE, 32'h0, 3'd2, 1'b0, 32'h0);

      // Error responses leave RAM alone; a transfer presented during ERR2 completes OKAY.
      act = 0;
      bus(1'b1, T_NSEQ, 32'h00, 3'd2, 1'b1, 32'h1234_5678);
      bus(1'b1, T_NSEQ, 32'h30, 3'd2, 1'b1, 32'h0BAD_F00D);
      bus(1'b1, T_NSEQ, 32'h02, 3'd2, 1'b1, 32'hFFFF_FFFF);
      bus(1'b1, T_NSEQ, 32'h30, 3'd3, 1'b1, 32'hFFFF_FFFF);
      bus(1'b1, T_NSEQ, 32'h05, 3'd1, 1'b1, 32'hFFFF_FFFF);
      bus(1'b1, T_NSEQ, 32'h320, 3'd2, 1'b0, 32'h0);
      bus(1'b1, T_NSEQ, 32'h00, 3'd2, 1'b0, 32'h0);
      bus(1'b1, T_NSEQ, 32'h30, 3'd2, 1'b0, 32'h0);
      bus(1'b1, T_NSEQ, 32'h04, 3'd2, 1'b0, 32'h0);
      bus(1'b0, T_IDLE, 32'h0, 3'd2, 1'b0, 32'h0);

      // No accept while another slave stalls, on BUSY, or when unselected.
      HWDATA = 32'hFFFF_FFFF;
      ext_stall = 1'b1;
      HSEL = 1'b1; HTRANS = T_NSEQ; HADDR = 32'h00; HSIZE = 3'd2; HWRITE = 1'b1;
      @(posedge HCLK); @(negedge HCLK);
      chk("stall_ready", {31'd0, ready_a[0]}, 32'd1);
      chk("stall_resp", {31'd0, resp_a[0]}, 32'd0);
      ext_stall = 1'b0;
      HTRANS = T_BUSY;
      @(posedge HCLK); @(negedge HCLK);
      chk("busy_ready", {31'd0, ready_a[0]}, 32'd1);
      HTRANS = T_NSEQ; HSEL = 1'b0;
      @(posedge HCLK); @(negedge HCLK);
      chk("unsel_ready", {31'd0, ready_a[0]}, 32'd1);
      chk("unsel_resp", {31'd0, resp_a[0]}, 32'd0);
      pend_wdata = 32'd0;
      bus(1'b1, T_NSEQ, 32'h00, 3'd2, 1'b0, 32'h0);
      bus(1'b0, T_IDLE, 32'h0, 3'd2, 1'b0, 32'h0);

      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
